// File: rtl/ram_cell.sv
// ram_cell: single-word synchronous storage cell.
//
// One WIDTH-bit register with independent write and read enables. Reads
// are registered (1-cycle latency) and a simultaneous write and read on
// the same edge returns the data being written (write-first).
//
// Ports:
//   clock    in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high; loads INIT_VALUE into
//                        storage and rd, clears rd_valid
//   we       in   1      write enable
//   wd       in   WIDTH  write data
//   re       in   1      read enable
//   rd       out  WIDTH  registered read data, holds between reads
//   rd_valid out  1      high for the cycle after an accepted read
module ram_cell #(
    parameter int              WIDTH      = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    output logic [WIDTH-1:0] rd,
    output logic             rd_valid
);

    logic [WIDTH-1:0] mem_q, mem_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
        mem_d      = mem_q;
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        if (we) begin
            mem_d = wd;
        end
        if (re) begin
            // Write-first: a same-edge write bypasses storage into rd.
            rd_d       = we ? wd : mem_q;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q      <= INIT_VALUE;
            rd_q       <= INIT_VALUE;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd       = rd_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_cell.sv
// Bench for ram_cell: a 1-bit default instance and an 8-bit instance with a
// non-zero INIT_VALUE, driven by directed steps and then random traffic
// with occasional asynchronous resets, compared each cycle to a model.
module tb_ram_cell;

    localparam logic [7:0] INIT8 = 8'h81;

    logic       clk = 1'b0;
    logic       reset;
    logic       we1, re1, we8, re8;
    logic [0:0] wd1, rd1;
    logic [7:0] wd8, rd8;
    logic       rdv1, rdv8;

    // Reference state: what storage and outputs must hold right now.
    logic [0:0] m_mem1, m_rd1;
    logic [7:0] m_mem8, m_rd8;
    logic       m_v1, m_v8;
    bit         chk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_cell u_c1 (
        .clock(clk), .reset(reset), .we(we1), .wd(wd1), .re(re1),
        .rd(rd1), .rd_valid(rdv1)
    );

    ram_cell #(.WIDTH(8), .INIT_VALUE(INIT8)) u_c8 (
        .clock(clk), .reset(reset), .we(we8), .wd(wd8), .re(re8),
        .rd(rd8), .rd_valid(rdv8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rd1", 32'(rd1), 32'(m_rd1));
            check("rd_valid1", 32'(rdv1), 32'(m_v1));
            check("rd8", 32'(rd8), 32'(m_rd8));
            check("rd_valid8", 32'(rdv8), 32'(m_v8));
        end
    end

    function automatic void model_reset();
        m_mem1 = 1'b0;  m_rd1 = 1'b0;  m_v1 = 1'b0;
        m_mem8 = INIT8; m_rd8 = INIT8; m_v8 = 1'b0;
    endfunction

    // One clock: apply inputs, let the edge happen, advance the model.
    task automatic cyc(input logic w1, input logic [0:0] d1, input logic r1,
                       input logic w8, input logic [7:0] d8, input logic r8);
        we1 = w1; wd1 = d1; re1 = r1;
        we8 = w8; wd8 = d8; re8 = r8;
        @(posedge clk);
        if (!reset) begin
            m_v1 = r1;
            if (r1) m_rd1 = w1 ? d1 : m_mem1;
            if (w1) m_mem1 = d1;
            m_v8 = r8;
            if (r8) m_rd8 = w8 ? d8 : m_mem8;
            if (w8) m_mem8 = d8;
        end
        #1;
    endtask

    // Raise reset between edges and confirm outputs clear without a clock.
    task automatic async_reset(input string name);
        reset = 1'b1;
        model_reset();
        #1;
        check({name, "_rd1"}, 32'(rd1), 32'h0);
        check({name, "_rdv1"}, 32'(rdv1), 32'h0);
        check({name, "_rd8"}, 32'(rd8), 32'(INIT8));
        check({name, "_rdv8"}, 32'(rdv8), 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        we1 = 0; wd1 = 0; re1 = 0; we8 = 0; wd8 = 0; re8 = 0;
        model_reset();
        #2;

        // Reset: immediate clear, and held reset overrides we/re.
        async_reset("reset_rise");
        chk_en = 1'b1;
        cyc(1, 1'b1, 1, 1, 8'hFF, 1);
        cyc(1, 1'b1, 1, 1, 8'hFF, 1);
        check("reset_hold_rd8", 32'(rd8), 32'h81);
        reset = 1'b0;

        // Write then read.
        cyc(1, 1'b1, 0, 0, 8'h00, 0);
        cyc(0, 1'b0, 1, 0, 8'h00, 0);
        check("wr_rd_rd1", 32'(rd1), 32'h1);
        check("wr_rd_rdv1", 32'(rdv1), 32'h1);

        // Hold for three idle cycles.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b0, 0, 0, 8'h00, 0);
            check("hold_rd1", 32'(rd1), 32'h1);
            check("hold_rdv1", 32'(rdv1), 32'h0);
        end

        // Overwrite, then write-first on a shared edge.
        cyc(1, 1'b0, 0, 0, 8'h00, 0);
        cyc(0, 1'b0, 1, 0, 8'h00, 0);
        check("overwrite_rd1", 32'(rd1), 32'h0);
        cyc(1, 1'b1, 1, 0, 8'h00, 0);
        check("wfirst_rd1", 32'(rd1), 32'h1);

        // Reset mid-operation after storing 1; a later read returns 0.
        async_reset("mid_reset");
        #2;
        reset = 1'b0;
        cyc(0, 1'b0, 1, 0, 8'h00, 1);
        check("post_reset_rd1", 32'(rd1), 32'h0);
        check("post_reset_rdv1", 32'(rdv1), 32'h1);
        check("post_reset_rd8", 32'(rd8), 32'h81);

        // 8-bit data path.
        cyc(0, 1'b0, 0, 1, 8'hA5, 0);
        cyc(0, 1'b0, 0, 0, 8'h00, 1);
        check("w8_a5", 32'(rd8), 32'hA5);
        cyc(0, 1'b0, 0, 1, 8'h3C, 0);
        check("w8_hold", 32'(rd8), 32'hA5);
        check("w8_hold_v", 32'(rdv8), 32'h0);
        cyc(0, 1'b0, 0, 0, 8'h00, 1);
        check("w8_3c", 32'(rd8), 32'h3C);
        cyc(0, 1'b0, 0, 1, 8'h5E, 1);
        check("w8_wfirst", 32'(rd8), 32'h5E);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_reset");
                #2;
                reset = 1'b0;
            end
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
